// File: rtl/spi_mem_responder_if.sv
// SPI pin and memory-bus bundle for spi_mem_responder.
// The responder uses the slave view; the host/memory side uses the master view.
interface spi_mem_responder_if;
  logic        spi_sclk;
  logic        spi_cs;
  logic        spi_sdi0;
  logic        spi_sdo0;
  logic [1:0]  spi_mode;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  spi_sclk, spi_cs, spi_sdi0, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output spi_sdo0, spi_mode, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output spi_sclk, spi_cs, spi_sdi0, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  spi_sdo0, spi_mode, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/spi_mem_responder.sv
// Mode-0 SPI slave turning write-mem / read-mem frames into single memory-bus accesses.
// Optional SPI_MEM_AUTOINC_EN: continued clocking streams further words at address+4.
module spi_mem_responder #(
  parameter int unsigned DUMMY_CYCLES = 32,
  parameter logic [7:0]  CMD_WR       = 8'h02,
  parameter logic [7:0]  CMD_RD       = 8'h0B
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  spi_mem_responder_if.slave bus,
  output logic               rd_late_o
);
  localparam int unsigned CNT_MAX = (DUMMY_CYCLES > 32) ? DUMMY_CYCLES : 32;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, WR_BUS, DUMMY, RDATA, IGNORE} state_e;

  state_e        state_q, state_d;
  logic [2:0]    sclk_q, cs_q, sdi_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   shift_q, shift_d, frame_addr_q, frame_addr_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, tx_q, tx_d;
  logic          is_rd_q, is_rd_d, req_q, req_d, we_q, we_d, sdo_q, sdo_d;
  logic          rd_late_q, rd_late_d, rd_out_q, rd_out_d, rd_got_q, rd_got_d;
`ifdef SPI_MEM_AUTOINC_EN
  logic [31:0]   nxt_q, nxt_d;
  logic          nxt_got_q, nxt_got_d, nxt_pend_q, nxt_pend_d;
  logic          nxt_ok;
`endif

  // Index 1 is the synchronized level, index 2 the history flop.
  logic sclk_rise, sclk_fall, cs_s, cs_fall, sdi_s, got_now;
  logic [31:0] shift_nxt;
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_s      = cs_q[1];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign sdi_s     = sdi_q[2];
  assign shift_nxt = {shift_q[30:0], sdi_s};
  assign got_now   = rd_got_q | (rd_out_q & bus.mem_rvalid_i);
`ifdef SPI_MEM_AUTOINC_EN
  assign nxt_ok    = nxt_got_q | (nxt_pend_q & rd_out_q & bus.mem_rvalid_i);
`endif

  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;  shift_d = shift_q;  frame_addr_d = frame_addr_q;
    addr_d = addr_q;  wdata_d = wdata_q;  tx_d = tx_q;  is_rd_d = is_rd_q;
    req_d = req_q;  we_d = we_q;  sdo_d = sdo_q;  rd_late_d = rd_late_q;
    rd_out_d = rd_out_q;  rd_got_d = rd_got_q;
`ifdef SPI_MEM_AUTOINC_EN
    nxt_d = nxt_q;  nxt_got_d = nxt_got_q;  nxt_pend_d = nxt_pend_q;
`endif
    // The bus handshake runs independently of the frame so an abort never drops it.
    if (req_q && bus.mem_gnt_i) req_d = 1'b0;
    if (rd_out_q && bus.mem_rvalid_i) begin
      rd_out_d = 1'b0;
      if (state_q == DUMMY) begin
        tx_d     = bus.mem_rdata_i;
        rd_got_d = 1'b1;
      end
`ifdef SPI_MEM_AUTOINC_EN
      else if (state_q == RDATA && nxt_pend_q) begin
        nxt_d     = bus.mem_rdata_i;
        nxt_got_d = 1'b1;
      end
`endif
    end

    if (cs_s) begin
      state_d  = IDLE;
      cnt_d    = '0;
      sdo_d    = 1'b0;
      rd_got_d = 1'b0;
`ifdef SPI_MEM_AUTOINC_EN
      nxt_pend_d = 1'b0;
      nxt_got_d  = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: if (cs_fall) begin
          state_d = CMD;
          cnt_d   = '0;
        end
        CMD: if (sclk_rise) begin
          shift_d = shift_nxt;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(7)) begin
            cnt_d   = '0;
            is_rd_d = (shift_nxt[7:0] == CMD_RD);
            state_d = (shift_nxt[7:0] == CMD_WR || shift_nxt[7:0] == CMD_RD) ? ADDR : IGNORE;
          end
        end
        ADDR: if (sclk_rise) begin
          shift_d = shift_nxt;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(31)) begin
            cnt_d        = '0;
            frame_addr_d = shift_nxt;
            if (is_rd_q) begin
              state_d  = DUMMY;
              req_d    = 1'b1;
              we_d     = 1'b0;
              addr_d   = shift_nxt;
              rd_out_d = 1'b1;
              rd_got_d = 1'b0;
            end else begin
              state_d = WDATA;
            end
          end
        end
        WDATA: if (sclk_rise) begin
          shift_d = shift_nxt;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(31)) begin
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = 1'b1;
            addr_d  = frame_addr_q;
            wdata_d = shift_nxt;
`ifdef SPI_MEM_AUTOINC_EN
            frame_addr_d = frame_addr_q + 32'd4;
`else
            state_d = WR_BUS;
`endif
          end
        end
        WR_BUS: if (req_q && bus.mem_gnt_i) state_d = IGNORE;
        DUMMY: if (sclk_rise) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DUMMY_CYCLES - 1)) begin
            cnt_d   = '0;
            state_d = RDATA;
            if (!got_now) begin
              tx_d      = '0;
              rd_late_d = 1'b1;
            end
          end
        end
        RDATA: begin
          // tx[31] goes out on each fall, starting with the fall that ends the last dummy bit.
          if (sclk_fall) begin
            sdo_d = tx_q[31];
            tx_d  = {tx_q[30:0], 1'b0};
          end
          if (sclk_rise) begin
            cnt_d = cnt_q + CW'(1);
`ifdef SPI_MEM_AUTOINC_EN
            if (cnt_q == '0 && !rd_out_q && !req_q) begin
              req_d        = 1'b1;
              we_d         = 1'b0;
              addr_d       = frame_addr_q + 32'd4;
              frame_addr_d = frame_addr_q + 32'd4;
              rd_out_d     = 1'b1;
              nxt_pend_d   = 1'b1;
              nxt_got_d    = 1'b0;
            end
            if (cnt_q == CW'(31)) begin
              cnt_d      = '0;
              tx_d       = nxt_ok ? (nxt_got_q ? nxt_q : bus.mem_rdata_i) : 32'd0;
              rd_late_d  = rd_late_q | ~nxt_ok;
              nxt_pend_d = 1'b0;
              nxt_got_d  = 1'b0;
            end
`else
            if (cnt_q == CW'(31)) begin
              cnt_d   = '0;
              state_d = IGNORE;
              sdo_d   = 1'b0;
            end
`endif
          end
        end
        IGNORE: sdo_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_q <= '0;  cs_q <= '1;  sdi_q <= '0;
      state_q <= IDLE;  cnt_q <= '0;  shift_q <= '0;  frame_addr_q <= '0;
      addr_q <= '0;  wdata_q <= '0;  tx_q <= '0;  is_rd_q <= 1'b0;
      req_q <= 1'b0;  we_q <= 1'b0;  sdo_q <= 1'b0;  rd_late_q <= 1'b0;
      rd_out_q <= 1'b0;  rd_got_q <= 1'b0;
`ifdef SPI_MEM_AUTOINC_EN
      nxt_q <= '0;  nxt_got_q <= 1'b0;  nxt_pend_q <= 1'b0;
`endif
    end else begin
      sclk_q <= {sclk_q[1:0], bus.spi_sclk};
      cs_q   <= {cs_q[1:0], bus.spi_cs};
      sdi_q  <= {sdi_q[1:0], bus.spi_sdi0};
      state_q <= state_d;  cnt_q <= cnt_d;  shift_q <= shift_d;  frame_addr_q <= frame_addr_d;
      addr_q <= addr_d;  wdata_q <= wdata_d;  tx_q <= tx_d;  is_rd_q <= is_rd_d;
      req_q <= req_d;  we_q <= we_d;  sdo_q <= sdo_d;  rd_late_q <= rd_late_d;
      rd_out_q <= rd_out_d;  rd_got_q <= rd_got_d;
`ifdef SPI_MEM_AUTOINC_EN
      nxt_q <= nxt_d;  nxt_got_q <= nxt_got_d;  nxt_pend_q <= nxt_pend_d;
`endif
    end
  end

  assign bus.spi_sdo0    = sdo_q;
  assign bus.spi_mode    = 2'b00;
  assign bus.mem_req_o   = req_q;
  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign rd_late_o       = rd_late_q;
endmodule

// File: tb/tb_spi_mem_responder.sv
// Bench for spi_mem_responder: SPI host driver, memory model, and queue-based bus/readback scoreboards.
module tb_spi_mem_responder;
  localparam int HALF = 8;  // clk_i cycles per sclk half period

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rd_late;
  always #5 clk = ~clk;

  spi_mem_responder_if bus ();
  spi_mem_responder dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus), .rd_late_o(rd_late));

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_txn_t;

  int checks = 0;
  int errors = 0;
  bus_txn_t    exp_bus_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] rx_q[$];
  logic [31:0] mem [logic [31:0]];
  int gnt_delay = 2;
  int rd_delay  = 3;
  int req_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: grant after gnt_delay cycles, return read data rd_delay cycles after grant.
  initial begin
    logic we_l;
    logic [31:0] a_l, d_l;
    bus.mem_gnt_i = 1'b0;  bus.mem_rvalid_i = 1'b0;  bus.mem_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_req_o) begin
        we_l = bus.mem_we_o;  a_l = bus.mem_addr_o;  d_l = bus.mem_wdata_o;
        repeat (gnt_delay) begin @(posedge clk); #1; end
        bus.mem_gnt_i = 1'b1;
        @(posedge clk); #1;
        bus.mem_gnt_i = 1'b0;
        if (we_l) mem[a_l] = d_l;
        else begin
          repeat (rd_delay - 1) begin @(posedge clk); #1; end
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i  = mem.exists(a_l) ? mem[a_l] : 32'd0;
          @(posedge clk); #1;
          bus.mem_rvalid_i = 1'b0;
        end
      end
    end
  end

  // Bus monitor: every accepted request is scored against the expected queue.
  initial begin
    bus_txn_t e;
    logic drop_pend = 1'b0;
    logic [31:0] snap_addr = '0;
    logic prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (drop_pend) begin
        check("req_drop", {31'd0, bus.mem_req_o}, 32'd0);
        drop_pend = 1'b0;
      end
      if (bus.mem_req_o) req_cycles++;
      if (bus.mem_req_o && !prev_req) snap_addr = bus.mem_addr_o;
      prev_req = bus.mem_req_o;
      if (bus.mem_req_o && bus.mem_gnt_i) begin
        drop_pend = 1'b1;
        if (exp_bus_q.size() == 0) begin
          checks++;  errors++;
          $display("FAIL bus_unexpected: got we=%b addr=%h wdata=%h expected no request",
                   bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o);
        end else begin
          e = exp_bus_q.pop_front();
          check("bus_we",     {31'd0, bus.mem_we_o}, {31'd0, e.we});
          check("bus_addr",   bus.mem_addr_o, e.addr);
          check("bus_stable", bus.mem_addr_o, snap_addr);
          if (e.we) check("bus_wdata", bus.mem_wdata_o, e.wdata);
        end
      end
    end
  end

  // Readback monitor: host-received words against expected read data.
  initial begin
    logic [31:0] w;
    forever begin
      @(negedge clk);
      if (rx_q.size() > 0) begin
        w = rx_q.pop_front();
        if (exp_rd_q.size() == 0) begin
          checks++;  errors++;
          $display("FAIL rd_unexpected: got %h expected nothing", w);
        end else check("rd_data", w, exp_rd_q.pop_front());
      end
    end
  end

  task automatic bit_x(input logic b, output logic s);
    bus.spi_sdi0 = b;
    repeat (HALF) @(negedge clk);
    s = bus.spi_sdo0;
    bus.spi_sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    bus.spi_sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n, inout int ones);
    logic s;
    for (int i = n - 1; i >= 0; i--) begin
      bit_x(v[i], s);
      ones += int'(s);
    end
  endtask

  task automatic recv_word(output logic [31:0] w);
    logic s;
    w = '0;
    for (int i = 0; i < 32; i++) begin
      bit_x(1'b0, s);
      w = {w[30:0], s};
    end
  endtask

  task automatic cs_start();
    bus.spi_cs = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (HALF) @(negedge clk);
    bus.spi_cs = 1'b1;
    repeat (4 * HALF) @(negedge clk);
  endtask

  task automatic read_frame(input logic [31:0] addr);
    int ones = 0;
    logic [31:0] w;
    cs_start();
    send_bits(32'h0B, 8, ones);
    send_bits(addr, 32, ones);
    send_bits(32'd0, 32, ones);
    recv_word(w);
    rx_q.push_back(w);
    cs_end();
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int ones;
    int req_before;
    logic s;
    bus.spi_sclk = 1'b0;  bus.spi_cs = 1'b1;  bus.spi_sdi0 = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_sdo",   {31'd0, bus.spi_sdo0}, 32'd0);
    check("rst_req",   {31'd0, bus.mem_req_o}, 32'd0);
    check("rst_we",    {31'd0, bus.mem_we_o}, 32'd0);
    check("rst_addr",  bus.mem_addr_o, 32'd0);
    check("rst_wdata", bus.mem_wdata_o, 32'd0);
    check("rst_late",  {31'd0, rd_late}, 32'd0);
    check("spi_mode",  {30'd0, bus.spi_mode}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Write 128 to address 128.
    exp_bus_q.push_back('{we: 1'b1, addr: 32'd128, wdata: 32'd128});
    ones = 0;
    cs_start();
    send_bits(32'h02, 8, ones);
    send_bits(32'd128, 32, ones);
    send_bits(32'd128, 32, ones);
    cs_end();
    repeat (20) @(negedge clk);

    // Read back address 128, data returned 3 cycles after grant.
    exp_bus_q.push_back('{we: 1'b0, addr: 32'd128, wdata: 32'd0});
    exp_rd_q.push_back(32'd128);
    read_frame(32'd128);
    check("rd_late_ok", {31'd0, rd_late}, 32'd0);

    // Unknown command: no request and sdo held low.
    req_before = req_cycles;
    ones = 0;
    cs_start();
    send_bits(32'hA5, 8, ones);
    send_bits(32'hFFFF_FFFF, 32, ones);
    send_bits(32'h5A5A_C3C3, 32, ones);
    cs_end();
    check("unk_sdo", ones, 32'd0);
    check("unk_req", req_cycles - req_before, 32'd0);

    // Abort after 20 address bits.
    req_before = req_cycles;
    ones = 0;
    cs_start();
    send_bits(32'h0B, 8, ones);
    send_bits(32'h000A_BCDE, 20, ones);
    cs_end();
    repeat (40) @(negedge clk);
    check("abort_addr_req", req_cycles - req_before, 32'd0);

    // Abort right after a write request while grant is held off for 10 cycles.
    gnt_delay = 10;
    exp_bus_q.push_back('{we: 1'b1, addr: 32'h40, wdata: 32'hDEAD_BEEF});
    ones = 0;
    cs_start();
    send_bits(32'h02, 8, ones);
    send_bits(32'h40, 32, ones);
    send_bits(32'hDEAD_BEEF >> 1, 31, ones);
    bus.spi_sdi0 = 1'b1;
    repeat (HALF) @(negedge clk);
    bus.spi_sclk = 1'b1;
    repeat (6) @(negedge clk);
    bus.spi_cs = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_req_held", {31'd0, bus.mem_req_o}, 32'd1);
    repeat (30) @(negedge clk);
    check("abort_req_done", {31'd0, bus.mem_req_o}, 32'd0);
    bus.spi_sclk = 1'b0;
    repeat (4 * HALF) @(negedge clk);
    gnt_delay = 2;

`ifdef SPI_MEM_AUTOINC_EN
    // Three streamed words wrapping through the top of the address space.
    exp_bus_q.push_back('{we: 1'b1, addr: 32'hFFFF_FFF8, wdata: 32'h1111_0001});
    exp_bus_q.push_back('{we: 1'b1, addr: 32'hFFFF_FFFC, wdata: 32'h2222_0002});
    exp_bus_q.push_back('{we: 1'b1, addr: 32'h0000_0000, wdata: 32'h3333_0003});
    ones = 0;
    cs_start();
    send_bits(32'h02, 8, ones);
    send_bits(32'hFFFF_FFF8, 32, ones);
    send_bits(32'h1111_0001, 32, ones);
    send_bits(32'h2222_0002, 32, ones);
    send_bits(32'h3333_0003, 32, ones);
    cs_end();
    repeat (20) @(negedge clk);
`else
    // Extra clocks after one write word must not produce a second write.
    exp_bus_q.push_back('{we: 1'b1, addr: 32'h200, wdata: 32'h1234_5678});
    ones = 0;
    cs_start();
    send_bits(32'h02, 8, ones);
    send_bits(32'h200, 32, ones);
    send_bits(32'h1234_5678, 32, ones);
    send_bits(32'hFFFF_FFFF, 32, ones);
    cs_end();
    check("extra_sdo", ones, 32'd0);
    repeat (20) @(negedge clk);
`endif

    // Late read: data withheld well past the dummy window.
    rd_delay = 1000;
    exp_bus_q.push_back('{we: 1'b0, addr: 32'd128, wdata: 32'd0});
    exp_rd_q.push_back(32'd0);
    read_frame(32'd128);
    check("rd_late_set", {31'd0, rd_late}, 32'd1);
    repeat (1100) @(negedge clk);
    check("rd_late_sticky", {31'd0, rd_late}, 32'd1);
    check("late_sdo_idle", {31'd0, bus.spi_sdo0}, 32'd0);

    repeat (50) @(negedge clk);
    check("bus_q_left", exp_bus_q.size(), 32'd0);
    check("rd_q_left",  exp_rd_q.size(), 32'd0);
    check("rx_q_left",  rx_q.size(), 32'd0);
    s = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_mem_responder.md
Name: spi_mem_responder

Overview:
- Single-lane SPI slave (mode 0: CPOL=0, CPHA=0) that decodes host SPI transactions into memory bus accesses.
- Sits between the chip SPI pads and the core memory interconnect.
- Serves the host-side write-mem (cmd 0x02) and read-mem (cmd 0x0B) frames.
- Fully synchronous to clk_i; SPI pins are synchronized and edge-detected internally, not used as clocks.

Parameters:
- DUMMY_CYCLES, 32, number of sclk cycles between the last address bit and the first read-data bit.
- CMD_WR, 8'h02, write-memory command code.
- CMD_RD, 8'h0B, read-memory command code.

Ports:
- clk_i  in  1  system clock; must run at least 4x spi_sclk.
- rst_ni  in  1  asynchronous active-low reset.
- spi_sclk  in  1  SPI clock from host.
- spi_cs  in  1  chip select, active low.
- spi_sdi0  in  1  serial data from host, MSB first.
- spi_sdo0  out  1  serial data to host, MSB first.
- spi_mode  out  2  lane mode; constant 2'b00 (single).
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  32  byte address.
- mem_wdata_o  out  32  write data.
- mem_gnt_i  in  1  request accepted.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  32  read data.
- rd_late_o  out  1  sticky: read data was not ready when output started.

Behaviour:
- Clock and reset are fixed: one clock, clk_i; reset rst_ni is asynchronous and active-low.
- Synchronization: spi_sclk, spi_cs and spi_sdi0 each pass through a 2-flop synchronizer plus one history flop.
  - rise = sync & ~hist; fall = ~sync & hist.
  - sdi is sampled on rise.
- Reset values: all state IDLE; spi_sdo0=0; mem_req_o=0; mem_we_o=0; mem_addr_o=0; mem_wdata_o=0; rd_late_o=0; bit counter=0.
- FSM states: IDLE, CMD, ADDR, WDATA, WR_BUS, DUMMY, RDATA, IGNORE.
  - IDLE -> CMD on synchronized cs falling.
  - CMD: shift 8 bits. On the 8th rise: CMD_WR or CMD_RD -> ADDR; any other code -> IGNORE.
  - ADDR: shift 32 bits. On the 32nd rise: write -> WDATA. Read -> DUMMY, and assert mem_req_o=1, mem_we_o=0, mem_addr_o=addr.
  - WDATA: shift 32 bits. On the 32nd rise: WR_BUS with mem_req_o=1, mem_we_o=1, addr and data latched.
  - WR_BUS: hold the request until mem_gnt_i, then mem_req_o=0 -> IGNORE (waits for cs high).
  - DUMMY: count DUMMY_CYCLES rises.
    - mem_req_o drops the cycle after mem_gnt_i.
    - On mem_rvalid_i, latch mem_rdata_i into the tx register.
    - After the last dummy rise -> RDATA.
    - If rvalid has not arrived by then: tx register = 0 and rd_late_o=1.
  - RDATA: spi_sdo0 = tx[31] is presented before the first RDATA sclk rise, i.e. driven on the fall that ends the last dummy bit. Shift left on each fall. After 32 bits -> IGNORE.
  - IGNORE: spi_sdo0=0; leave only on cs high.
- cs rising in any state -> IDLE within 3 clk_i cycles and counters clear. Exception: an outstanding mem_req_o stays asserted until mem_gnt_i; the bus handshake is never dropped. A late rvalid after abort is discarded.
- The bus protocol requires mem_addr_o, mem_we_o and mem_wdata_o stable while mem_req_o=1 and gnt=0.
- Simultaneous cs rise and sclk rise: cs wins; that bit is discarded.
- Only one bus transaction is outstanding at a time.
- rd_late_o clears on reset only.
- Total latency: a write is issued 3–4 clk_i after the 72nd sclk rise.

Optional Feature:
- Macro: SPI_MEM_AUTOINC_EN.
- With the macro defined:
  - Write: after each 32-bit WDATA word, continued clocking stays in WDATA, and the next word goes to address+4 (32-bit wrap, 0xFFFFFFFC -> 0x0).
  - Read: after each RDATA word, a new read at address+4 is issued on the 1st rise of the current word. If it is not returned by the last fall, the next word is 0 and rd_late_o=1.
- Without it: exactly one word per frame; further clocks are ignored (IGNORE, sdo0=0).

Test Plan:
- Write: cmd 0x02, addr 128, data 128 -> one mem_req_o with we=1, addr=128, wdata=128; gnt after 2 cycles -> req deasserts the next cycle.
- Read-back: cmd 0x0B, addr 128, memory returns 128 after 3 cycles -> 32 bits on spi_sdo0 decode to 128; rd_late_o=0.
- Unknown cmd 0xA5 followed by 64 sclks -> no mem_req_o, spi_sdo0=0 throughout.
- Abort: cs high after 20 address bits -> IDLE, no request. Abort after a write request with gnt held low 10 cycles -> req stays 1 until gnt, then 0.
- Late read: rvalid withheld beyond DUMMY_CYCLES=32 -> host reads 0x00000000, rd_late_o=1.
- With SPI_MEM_AUTOINC_EN: write 3 words from addr 0xFFFFFFF8 -> writes at 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
